// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared types and constants for the fetch front end.
//   XLEN         : architectural register / address width
//   RESET_PC     : first PC fetched after reset
//   NOP_INSTR    : ADDI x0,x0,0, used as bubble filler in IF/ID
//   ALIGN_MASK   : clears the low two bits of a fetch address
//   if_id_reg_t  : IF/ID pipeline register contents
//   fetch_state_t: fetch controller states
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h0000_0003;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic            valid_if_id;
  } if_id_reg_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage. Owns the PC, keeps at most one request in flight
// to instruction memory, and registers fetched words into IF/ID.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   synchronous, active-high
//   stall           in   hazard unit: hold if_id_out this cycle
//   redirect_valid  in   taken branch/jump from EX (beats stall)
//   redirect_pc     in   redirect target, low two bits ignored
//   imem_req_valid  out  fetch request valid
//   imem_req_addr   out  fetch address (= pc)
//   imem_req_ready  in   memory accepts the request
//   imem_rsp_valid  in   instruction returned
//   imem_rsp_data   in   instruction word
//   if_id_out       out  registered {pc, instruction, valid_if_id}
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | presenting a request for pc, waiting for ready
// WAIT  | request accepted, waiting for its response
// HOLD  | response captured in hold buffer while decode is stalled
// DROP  | waiting for a response whose fetch was squashed by redirect
module if_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output if_id_reg_t      if_id_out
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     hold_q, hold_d;
  if_id_reg_t      if_id_q, if_id_d;

  logic        req_fire;
  logic        load;
  logic [31:0] load_data;

  // Request outputs depend only on registered state and pc.
  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign if_id_out      = if_id_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    if_id_d   = if_id_q;
    load      = 1'b0;
    load_data = imem_rsp_data;

    unique case (state_q)
      REQ: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!stall) begin
            load    = 1'b1;
            state_d = REQ;
          end else begin
            hold_d  = imem_rsp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_data = hold_q;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (load) begin
      if_id_d.pc          = pc_q;
      if_id_d.instruction = load_data;
      if_id_d.valid_if_id = 1'b1;
      pc_d                = pc_q + 32'd4;
    end else if (!stall) begin
      // Bubble: pc field keeps its last value.
      if_id_d.instruction = NOP_INSTR;
      if_id_d.valid_if_id = 1'b0;
    end

    // Redirect wins over everything above, including stall. Whether an
    // outstanding response must still be absorbed decides REQ vs DROP.
    if (redirect_valid) begin
      pc_d                = redirect_pc & ALIGN_MASK;
      if_id_d.instruction = NOP_INSTR;
      if_id_d.valid_if_id = 1'b0;
      unique case (state_q)
        REQ:     state_d = req_fire ? DROP : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      if_id_q <= '{pc: '0, instruction: NOP_INSTR, valid_if_id: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      if_id_q <= if_id_d;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction memory over a valid/ready request and valid-only response interface, and registers fetched instructions into the IF/ID pipeline register that feeds decode. It honours hazard-unit stalls, accepts branch/jump redirects from EX, squashes in-flight fetches on redirect, and inserts bubbles (valid_if_id = 0) whenever no instruction is ready.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold if_id_out unchanged this cycle
- redirect_valid  in  1  EX resolved taken branch/jump; overrides stall
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0 internally
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  XLEN  word-aligned fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction returned (exactly one per accepted request, ≥1 cycle later)
- imem_rsp_data  in  32  instruction word
- if_id_out  out  if_id_reg_t  registered {pc, instruction, valid_if_id} to decode

## Operation
- State register fetch_state_t: REQ, WAIT, HOLD, DROP. Reset: REQ, pc = RESET_PC, hold buffer = 0.
- REQ: imem_req_valid = 1, imem_req_addr = pc. Handshake (valid & ready) -> WAIT; else stay.
- WAIT: on imem_rsp_valid: if !stall, load if_id_out = {pc, rsp_data, 1}, pc += 4, -> REQ; if stall, capture rsp_data in hold buffer, -> HOLD. No response: stay.
- HOLD: when !stall, load if_id_out = {pc, buffer, 1}, pc += 4, -> REQ.
- DROP: waiting for a squashed response; on imem_rsp_valid discard it, -> REQ. imem_req_valid = 0.
- imem_req_valid = 0 in WAIT, HOLD, DROP (single outstanding request).
- Redirect (highest priority, any state): pc = {redirect_pc[XLEN-1:2], 2'b00}; if_id_out.valid_if_id = 0, instruction = NOP; next state:
  - REQ with handshake same cycle -> DROP; REQ without handshake -> REQ.
  - WAIT with imem_rsp_valid same cycle -> REQ (response discarded); WAIT without -> DROP.
  - HOLD -> REQ (buffer discarded). DROP with rsp same cycle -> REQ, else DROP.
- if_id_out update when no redirect: stall = 1 -> hold all fields; stall = 0 and no instruction loaded this cycle -> bubble {pc unchanged, 32'h0000_0013, 0}.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset value of outputs: imem_req_valid = 1 (state REQ, registered state), imem_req_addr = RESET_PC, if_id_out = {0, 32'h0000_0013, 0}.
- imem_req_valid/imem_req_addr combinational from state and pc; no combinational path from imem_rsp_* or stall to request outputs.
- if_id_out is registered: instruction returned in cycle N is visible on if_id_out in N+1.
- Zero-wait memory (ready = 1, rsp one cycle after accept): request accepted in cycle 0, response in cycle 1, if_id_out valid in cycle 2; sustained throughput 1 instruction / 2 cycles.
- Redirect in cycle N: if_id_out bubble in N+1; request to target issued no earlier than N+1.
- Reset asserted mid-operation: all state returns to reset values next edge; any later response to a pre-reset request is undefined (memory is reset together).

## Structure
- riscv_pkg: fetch_state_t enum, NOP_INSTR = 32'h0000_0013, RESET_PC default constant; if_id_reg_t already lives there.
- Flat module; no sub-module warranted (state, pc, hold buffer, output register all in this block).

## Test plan
- Reset, ready = 1, 1-cycle memory returning 0x00500093 @0x0 -> if_id_out = {0x0, 0x00500093, 1} 2 cycles after reset release; next request addr 0x4.
- Memory ready held 0 for 3 cycles -> imem_req_addr stable at 0x0, if_id_out bubbles {.., 0x00000013, 0} each cycle.
- stall = 1 for 4 cycles while response arrives -> state HOLD, if_id_out frozen; stall drops -> buffered instruction appears next cycle, no request reissued.
- Redirect to 0x0000_0103 while in WAIT, response arrives 2 cycles later -> response dropped, next request addr 0x100, if_id_out bubble the cycle after redirect.
- Redirect same cycle as response in WAIT, and same cycle as stall -> response discarded, stall ignored, next request at target.
- pc = 0xFFFF_FFFC fetch completes -> next imem_req_addr = 0x0000_0000.
